// File: rtl/ahb_ram_slave_pkg.sv
// Shared encodings for the AHB RAM slave: transfer types, sizes, responses,
// FSM state codes and the byte-lane enable helper.
package ahb_ram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ERR1 = 2'd2;
  localparam state_t ST_ERR2 = 2'd3;

  // Little-endian lane mask for a transfer of the given size at byte offset offs.
  function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] offs);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << offs;
      HSIZE_HALF: be = offs[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite bus bundle between a master (or testbench) and the RAM slave.
interface ahb_ram_slave_if;
  logic        hsel;
  logic        hready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [6:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, hready, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_ram_array.sv
// MEM_WORDS x 32 single-port RAM: byte-enabled synchronous write, asynchronous
// read at the same address. Contents are not reset.
module ahb_ram_array #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave with error responses and pipelined data phases.
// Optional wait states are enabled with the AHB_SLV_WAIT_EN macro.
module ahb_ram_slave
  import ahb_ram_slave_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic           hclk,
  input  logic           hrstn,
  ahb_ram_slave_if.slave bus
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;
  localparam int          CW        = 8;
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
`ifdef AHB_SLV_WAIT_EN
  localparam logic WAIT_EN = (WAIT_CYCLES > 0);
`else
  localparam logic WAIT_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [2:0]    dp_size_q, dp_size_d;
  logic [AW+1:0] dp_offs_q, dp_offs_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic [31:0]   offs_s;
  logic          addr_err_s;
  logic          accept_s;
  logic          dp_end_s;
  logic          rd_active_s;
  logic [3:0]    ram_we_s;
  logic [31:0]   ram_rdata_s;
  logic          unused_s;

  assign offs_s = bus.haddr - BASE_ADDR;

  assign addr_err_s = (bus.hsize > HSIZE_WORD)
                    | ((bus.hsize == HSIZE_HALF) & offs_s[0])
                    | ((bus.hsize == HSIZE_WORD) & (offs_s[1:0] != 2'b00))
                    | (offs_s >= MEM_BYTES);

  // New address phases are only taken while this slave is not stalling its own data phase.
  assign accept_s = bus.hsel & bus.hready & hreadyout_q
                  & ((bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ));

  assign dp_end_s    = hreadyout_q & dp_valid_q;
  assign rd_active_s = dp_end_s & ~dp_write_q;
  assign ram_we_s    = (dp_end_s & dp_write_q) ? lane_enable(dp_size_q, dp_offs_q[1:0]) : 4'b0000;

  assign unused_s = ^{bus.hburst, bus.hprot, bus.hmastlock};

  ahb_ram_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we_s),
    .addr  (dp_offs_q[AW+1:2]),
    .wdata (bus.hwdata),
    .rdata (ram_rdata_s)
  );

  // Next-state, data-phase capture and response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_size_d   = dp_size_q;
    dp_offs_d   = dp_offs_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;

    if (rd_active_s) begin
      hrdata_d = ram_rdata_s;
    end else begin
      hrdata_d = hrdata_q;
    end

    // Errored transfers never open a RAM data phase.
    if (hreadyout_q) begin
      dp_valid_d = accept_s & ~addr_err_s;
      if (accept_s) begin
        dp_write_d = bus.hwrite;
        dp_size_d  = bus.hsize;
        dp_offs_d  = offs_s[AW+1:0];
      end else begin
        dp_write_d = dp_write_q;
        dp_size_d  = dp_size_q;
        dp_offs_d  = dp_offs_q;
      end
    end else begin
      dp_valid_d = dp_valid_q;
    end

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept_s && addr_err_s) begin
          state_d = ST_ERR1;
        end else if (accept_s && WAIT_EN) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY;  end
      ST_WAIT: begin hreadyout_d = 1'b0; hresp_d = HRESP_OKAY;  end
      ST_ERR1: begin hreadyout_d = 1'b0; hresp_d = HRESP_ERROR; end
      ST_ERR2: begin hreadyout_d = 1'b1; hresp_d = HRESP_ERROR; end
      default: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY;  end
    endcase
  end

  // State and data-phase registers.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= 3'd0;
      dp_offs_q   <= '0;
      hrdata_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_offs_q   <= dp_offs_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Read data is shown live during a read's final cycle, so a write committed on the
  // previous edge is visible immediately; otherwise the last read value is held.
  assign bus.hrdata    = rd_active_s ? ram_rdata_s : hrdata_q;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Self-checking bench for ahb_ram_slave: vector table plus hand-written pipelined,
// error-pipelined and reset corner cases. Honours AHB_SLV_WAIT_EN (WAIT_CYCLES=2).
module tb_ahb_ram_slave;
  import ahb_ram_slave_pkg::*;

`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  logic hclk = 1'b0;
  logic hrstn = 1'b0;
  always #5 hclk = ~hclk;

  ahb_ram_slave_if bus();
  assign bus.hready = bus.hreadyout;

  ahb_ram_slave #(
    .MEM_WORDS   (1024),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (2)
  ) dut (
    .hclk  (hclk),
    .hrstn (hrstn),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;
  vec_t        vecs[24];

  function automatic vec_t mk(logic wr, logic [2:0] sz, logic [31:0] addr,
                              logic [31:0] wd, logic err, logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [31:0] addr);
    bus.hsel   = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = wr;
    bus.hsize  = sz;
    bus.haddr  = addr;
  endtask

  task automatic drive_idle();
    bus.hsel   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwrite = 1'b0;
    bus.hsize  = HSIZE_BYTE;
    bus.haddr  = 32'h0;
  endtask

  // Ends on the negedge where hreadyout is high; checks the number of stall cycles.
  task automatic wait_ready(input string name);
    int lows;
    lows = 0;
    @(negedge hclk);
    while (bus.hreadyout !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge hclk);
    end
    chk({name, "_waits"}, 32'(lows), 32'(EXP_WAIT));
  endtask

  task automatic data_phase(input logic wr, input string name);
    logic [31:0] e;
    chk({name, "_hresp"}, {31'd0, bus.hresp}, {31'd0, HRESP_OKAY});
    if (wr) begin
      chk({name, "_hold"}, bus.hrdata, last_rd);
    end else begin
      chk({name, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({name, "_hrdata"}, bus.hrdata, e);
        last_rd = e;
      end
    end
  endtask

  task automatic err_phase(input string name);
    @(negedge hclk);
    chk({name, "_e1_ready"}, {31'd0, bus.hreadyout}, 32'd0);
    chk({name, "_e1_resp"},  {31'd0, bus.hresp},     32'd1);
    chk({name, "_e1_hold"},  bus.hrdata, last_rd);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk({name, "_e2_ready"}, {31'd0, bus.hreadyout}, 32'd1);
    chk({name, "_e2_resp"},  {31'd0, bus.hresp},     32'd1);
    @(posedge hclk); #1;
  endtask

  task automatic xfer(input vec_t v, input string name);
    drive_addr(v.wr, v.sz, v.addr);
    if (!v.wr && !v.err) exp_q.push_back(v.rd);
    @(posedge hclk); #1;
    drive_idle();
    bus.hwdata = v.wd;
    if (v.err) begin
      err_phase(name);
    end else begin
      wait_ready(name);
      data_phase(v.wr, name);
      @(posedge hclk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b1, HSIZE_WORD, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, HSIZE_WORD, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b1, HSIZE_WORD, 32'h010, 32'h11223344, 1'b0, 32'h0);
    vecs[3]  = mk(1'b1, HSIZE_BYTE, 32'h013, 32'hAA5A5A5A, 1'b0, 32'h0);
    vecs[4]  = mk(1'b0, HSIZE_WORD, 32'h010, 32'h0,        1'b0, 32'hAA223344);
    vecs[5]  = mk(1'b1, HSIZE_WORD, 32'h020, 32'h00000000, 1'b0, 32'h0);
    vecs[6]  = mk(1'b1, HSIZE_HALF, 32'h022, 32'hBEEF1234, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, HSIZE_WORD, 32'h020, 32'h0,        1'b0, 32'hBEEF0000);
    vecs[8]  = mk(1'b0, HSIZE_WORD, 32'h002, 32'h0,        1'b1, 32'h0);
    vecs[9]  = mk(1'b1, HSIZE_WORD, 32'h012, 32'hFFFFFFFF, 1'b1, 32'h0);
    vecs[10] = mk(1'b1, HSIZE_HALF, 32'h021, 32'hFFFFFFFF, 1'b1, 32'h0);
    vecs[11] = mk(1'b1, 3'd3,       32'h020, 32'hFFFFFFFF, 1'b1, 32'h0);
    vecs[12] = mk(1'b1, HSIZE_WORD, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0);
    vecs[13] = mk(1'b0, HSIZE_WORD, 32'h010, 32'h0,        1'b0, 32'hAA223344);
    vecs[14] = mk(1'b0, HSIZE_WORD, 32'h020, 32'h0,        1'b0, 32'hBEEF0000);
    vecs[15] = mk(1'b1, HSIZE_WORD, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    vecs[16] = mk(1'b0, HSIZE_WORD, 32'hFFC, 32'h0,        1'b0, 32'hCAFEF00D);
    vecs[17] = mk(1'b1, HSIZE_WORD, 32'h000, 32'h0BADC0DE, 1'b0, 32'h0);
    vecs[18] = mk(1'b0, HSIZE_WORD, 32'h000, 32'h0,        1'b0, 32'h0BADC0DE);
    vecs[19] = mk(1'b1, HSIZE_BYTE, 32'h000, 32'h11223377, 1'b0, 32'h0);
    vecs[20] = mk(1'b0, HSIZE_WORD, 32'h000, 32'h0,        1'b0, 32'h0BADC077);
    vecs[21] = mk(1'b1, HSIZE_HALF, 32'h000, 32'h99994321, 1'b0, 32'h0);
    vecs[22] = mk(1'b0, HSIZE_WORD, 32'h000, 32'h0,        1'b0, 32'h0BAD4321);
    vecs[23] = mk(1'b1, HSIZE_WORD, 32'h030, 32'h55AA55AA, 1'b0, 32'h0);

    drive_idle();
    bus.hburst    = 3'd0;
    bus.hprot     = 7'd0;
    bus.hmastlock = 1'b0;
    bus.hwdata    = 32'h0;

    #12;
    chk("rst_ready", {31'd0, bus.hreadyout}, 32'd1);
    chk("rst_resp",  {31'd0, bus.hresp},     32'd0);
    chk("rst_hrdata", bus.hrdata, 32'h0);
    @(negedge hclk); hrstn = 1'b1;
    @(posedge hclk); #1;

    for (int i = 0; i < 24; i++) begin
      xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // BUSY and unselected NONSEQ to an illegal address must both get a zero-wait OKAY.
    bus.hsel = 1'b1; bus.htrans = HTRANS_BUSY; bus.hsize = HSIZE_WORD; bus.haddr = 32'h3;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("busy_ready", {31'd0, bus.hreadyout}, 32'd1);
    chk("busy_resp",  {31'd0, bus.hresp},     32'd0);
    bus.hsel = 1'b0; bus.htrans = HTRANS_NONSEQ;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("nosel_ready", {31'd0, bus.hreadyout}, 32'd1);
    chk("nosel_resp",  {31'd0, bus.hresp},     32'd0);
    @(posedge hclk); #1;
    drive_idle();

    // Back-to-back write then read of the same word, no bubble.
    drive_addr(1'b1, HSIZE_WORD, 32'h020);
    @(posedge hclk); #1;
    bus.hwdata = 32'h12345678;
    drive_addr(1'b0, HSIZE_WORD, 32'h020);
    exp_q.push_back(32'h12345678);
    wait_ready("b2b_wr");
    data_phase(1'b1, "b2b_wr");
    @(posedge hclk); #1;
    drive_idle();
    wait_ready("b2b_rd");
    data_phase(1'b0, "b2b_rd");
    @(posedge hclk); #1;

    // Error response with a new transfer accepted during ERR2.
    drive_addr(1'b0, HSIZE_WORD, 32'h002);
    @(posedge hclk); #1;
    drive_idle();
    @(negedge hclk);
    chk("perr_e1_ready", {31'd0, bus.hreadyout}, 32'd0);
    chk("perr_e1_resp",  {31'd0, bus.hresp},     32'd1);
    drive_addr(1'b0, HSIZE_WORD, 32'h020);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("perr_e2_ready", {31'd0, bus.hreadyout}, 32'd1);
    chk("perr_e2_resp",  {31'd0, bus.hresp},     32'd1);
    exp_q.push_back(32'h12345678);
    @(posedge hclk); #1;
    drive_idle();
    wait_ready("perr_rd");
    data_phase(1'b0, "perr_rd");
    @(posedge hclk); #1;

    // Reset during the data phase of a write discards it.
    drive_addr(1'b1, HSIZE_WORD, 32'h030);
    @(posedge hclk); #1;
    drive_idle();
    bus.hwdata = 32'h01020304;
    #2;
    hrstn = 1'b0;
    #1;
    chk("mrst_ready",  {31'd0, bus.hreadyout}, 32'd1);
    chk("mrst_resp",   {31'd0, bus.hresp},     32'd0);
    chk("mrst_hrdata", bus.hrdata, 32'h0);
    last_rd = 32'h0;
    @(posedge hclk);
    @(negedge hclk); hrstn = 1'b1;
    @(posedge hclk); #1;
    xfer(mk(1'b0, HSIZE_WORD, 32'h030, 32'h0, 1'b0, 32'h55AA55AA), "mrst_rd");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
